// File: rtl/code_lock_pkg.sv
// Shared state encoding, 7-segment patterns and width helpers for code_lock.
package code_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY         = 3'd0,
    ST_OPEN          = 3'd1,
    ST_CHANGE_NEW    = 3'd2,
    ST_CHANGE_VERIFY = 3'd3,
    ST_LOCKOUT       = 3'd4
  } state_e;

  localparam int unsigned SEG_W   = 9;
  localparam int unsigned TIMER_W = 32;
  localparam int unsigned TRIES_W = 4;

  // digit_sel width: $clog2(DIGITS), never below one bit
  function automatic int unsigned sel_width(input int unsigned digits);
    return (digits <= 2) ? 1 : $clog2(digits);
  endfunction

  // gfedcba, active-high; non-BCD codes blank the digit
  function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
    logic [6:0] p;
    case (bcd)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// One BCD digit to a 9-bit {2'b00, gfedcba} display pattern.
module seg7_bcd_decode
  import code_lock_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = {2'b00, seg_pattern(bcd)};

endmodule

// File: rtl/code_lock.sv
// Digital combination lock with lockout, verified code change and idle relock.
// Optional MASTER_CODE_EN: MASTER_CODE opens in ENTRY and ends LOCKOUT early.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int unsigned          DIGITS      = 2,
  parameter int unsigned          MAX_TRIES   = 3,
  parameter int unsigned          LOCK_CYCLES = 50_000_000,
  parameter int unsigned          OPEN_CYCLES = 500_000_000,
  parameter logic [4*DIGITS-1:0]  INIT_CODE   = {DIGITS{4'd2}},
  parameter logic [4*DIGITS-1:0]  MASTER_CODE = {DIGITS{4'd9}},
  localparam int unsigned         SEL_W       = sel_width(DIGITS),
  localparam int unsigned         CODE_W      = 4 * DIGITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              sw,
  input  logic [SEL_W-1:0]        digit_sel,
  input  logic                    key_load,
  input  logic                    key_confirm,
  input  logic                    key_change,
  input  logic                    key_clear,
  output logic [CODE_W-1:0]       entry,
  output logic                    unlocked,
  output logic                    locked_out,
  output logic                    fail,
  output logic                    change_ok,
  output logic                    change_err,
  output logic [TRIES_W-1:0]      tries,
  output logic [SEG_W*DIGITS-1:0] seg
);

  state_e               state_q, state_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [CODE_W-1:0]    cand_q, cand_d;
  logic [CODE_W-1:0]    entry_d, entry_wr;
  logic [TRIES_W-1:0]   tries_d;
  logic [TIMER_W-1:0]   lock_tmr_q, lock_tmr_d;
  logic [TIMER_W-1:0]   idle_tmr_q, idle_tmr_d;
  logic                 fail_d, change_ok_d, change_err_d;
  logic                 unlocked_d, locked_out_d;
  logic [SEG_W*DIGITS-1:0] seg_d;
  logic                 do_clear, do_load, do_confirm, do_change, load_ok;
  logic                 key_hit;
  logic                 master_hit_c;

`ifdef MASTER_CODE_EN
  assign master_hit_c = (entry == MASTER_CODE);
`else
  logic unused_master;
  assign master_hit_c  = 1'b0;
  assign unused_master = ^MASTER_CODE;
`endif

  // Key arbitration: clear > load > confirm > change
  assign do_clear   = key_clear;
  assign do_load    = !key_clear && key_load;
  assign do_confirm = !key_clear && !key_load && key_confirm;
  assign do_change  = !key_clear && !key_load && !key_confirm && key_change;
  assign load_ok    = do_load && (sw <= 4'd9);

  // Entry with sw written at digit_sel; out-of-range selects match no digit
  always_comb begin
    entry_wr = entry;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (digit_sel == SEL_W'(k)) entry_wr[4*k +: 4] = sw;
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    cand_d       = cand_q;
    entry_d      = entry;
    tries_d      = tries;
    lock_tmr_d   = lock_tmr_q;
    idle_tmr_d   = idle_tmr_q;
    fail_d       = 1'b0;
    change_ok_d  = 1'b0;
    change_err_d = 1'b0;
    key_hit      = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (do_clear) entry_d = '0;
        else if (load_ok) entry_d = entry_wr;
        else if (do_confirm) begin
          entry_d = '0;
          if ((entry == code_q) || master_hit_c) begin
            state_d    = ST_OPEN;
            tries_d    = '0;
            idle_tmr_d = '0;
          end else begin
            fail_d = 1'b1;
            if (tries + 4'd1 >= TRIES_W'(MAX_TRIES)) begin
              tries_d    = TRIES_W'(MAX_TRIES);
              state_d    = ST_LOCKOUT;
              lock_tmr_d = TIMER_W'(LOCK_CYCLES - 1);
            end else begin
              tries_d = tries + 4'd1;
            end
          end
        end
      end

      ST_OPEN, ST_CHANGE_NEW, ST_CHANGE_VERIFY: begin
        key_hit = do_clear || load_ok || do_confirm || (do_change && (state_q == ST_OPEN));
        if (do_clear) entry_d = '0;
        else if (load_ok) entry_d = entry_wr;
        else if (do_confirm) begin
          entry_d = '0;
          if (state_q == ST_OPEN) begin
            state_d = ST_ENTRY;
          end else if (state_q == ST_CHANGE_NEW) begin
            cand_d  = entry;
            state_d = ST_CHANGE_VERIFY;
          end else begin
            if (entry == cand_q) begin
              code_d      = cand_q;
              change_ok_d = 1'b1;
            end else begin
              change_err_d = 1'b1;
            end
            state_d = ST_OPEN;
          end
        end else if (do_change && (state_q == ST_OPEN)) begin
          entry_d = '0;
          state_d = ST_CHANGE_NEW;
        end

        // Inactivity relock abandons any change in progress
        if (key_hit) begin
          idle_tmr_d = '0;
        end else if (idle_tmr_q >= TIMER_W'(OPEN_CYCLES - 1)) begin
          idle_tmr_d = '0;
          entry_d    = '0;
          state_d    = ST_ENTRY;
        end else begin
          idle_tmr_d = idle_tmr_q + TIMER_W'(1);
        end
      end

      ST_LOCKOUT: begin
`ifdef MASTER_CODE_EN
        if (do_clear) entry_d = '0;
        else if (load_ok) entry_d = entry_wr;
        else if (do_confirm) entry_d = '0;
        if (do_confirm && master_hit_c) begin
          state_d    = ST_ENTRY;
          tries_d    = '0;
          lock_tmr_d = '0;
          entry_d    = '0;
        end else
`endif
        if (lock_tmr_q == '0) begin
          state_d = ST_ENTRY;
          tries_d = '0;
          entry_d = '0;
        end else begin
          lock_tmr_d = lock_tmr_q - TIMER_W'(1);
        end
      end

      default: begin
        state_d = ST_ENTRY;
        entry_d = '0;
      end
    endcase

    unlocked_d   = (state_d == ST_OPEN) || (state_d == ST_CHANGE_NEW) ||
                   (state_d == ST_CHANGE_VERIFY);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  // Displays follow the next entry value so seg lines up with entry
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_bcd_decode u_dec (
      .bcd  (entry_d[4*g +: 4]),
      .seg_c(seg_d[SEG_W*g +: SEG_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTRY;
      code_q     <= INIT_CODE;
      cand_q     <= '0;
      entry      <= '0;
      tries      <= '0;
      lock_tmr_q <= '0;
      idle_tmr_q <= '0;
      fail       <= 1'b0;
      change_ok  <= 1'b0;
      change_err <= 1'b0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      seg        <= {DIGITS{{2'b00, seg_pattern(4'd0)}}};
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cand_q     <= cand_d;
      entry      <= entry_d;
      tries      <= tries_d;
      lock_tmr_q <= lock_tmr_d;
      idle_tmr_q <= idle_tmr_d;
      fail       <= fail_d;
      change_ok  <= change_ok_d;
      change_err <= change_err_d;
      unlocked   <= unlocked_d;
      locked_out <= locked_out_d;
      seg        <= seg_d;
    end
  end

endmodule

// File: tb/tb_code_lock.sv
// Self-checking bench for code_lock: directed table, corner sequences, random vs model.
module tb_code_lock;

  localparam int DIGITS      = 2;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 20;
  localparam int OPEN_CYCLES = 30;
`ifdef MASTER_CODE_EN
  localparam bit MASTER_ON = 1'b1;
`else
  localparam bit MASTER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sw;
  logic [0:0]  digit_sel;
  logic        key_load, key_confirm, key_change, key_clear;
  logic [7:0]  entry;
  logic        unlocked, locked_out, fail, change_ok, change_err;
  logic [3:0]  tries;
  logic [17:0] seg;

  code_lock #(
    .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES),
    .OPEN_CYCLES(OPEN_CYCLES), .INIT_CODE(8'h22), .MASTER_CODE(8'h99)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .digit_sel(digit_sel),
    .key_load(key_load), .key_confirm(key_confirm), .key_change(key_change),
    .key_clear(key_clear), .entry(entry), .unlocked(unlocked),
    .locked_out(locked_out), .fail(fail), .change_ok(change_ok),
    .change_err(change_err), .tries(tries), .seg(seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: codes held as decimal numbers, timers as absolute deadlines
  typedef enum int {M_ENTRY, M_OPEN, M_NEW, M_VERIFY, M_LOCK} mmode_e;
  mmode_e m_mode;
  int     m_dig[DIGITS];
  int     m_code, m_cand, m_tries;
  int     step_n = 0, lock_exit = 0, idle_exit = 0;
  bit     e_fail, e_ok, e_err;

  function automatic int entry_num();
    int v = 0;
    for (int k = DIGITS - 1; k >= 0; k--) v = v * 10 + m_dig[k];
    return v;
  endfunction

  task automatic clear_entry();
    for (int k = 0; k < DIGITS; k++) m_dig[k] = 0;
  endtask

  task automatic model_reset();
    m_mode = M_ENTRY; clear_entry();
    m_code = 22; m_cand = 0; m_tries = 0;
    e_fail = 0; e_ok = 0; e_err = 0;
  endtask

  task automatic entry_ops(input bit c, input bit ld_ok, input bit f, input int s, input int sel);
    if (c || f) clear_entry();
    else if (ld_ok) m_dig[sel] = s;
  endtask

  task automatic model_step(input bit c, input bit l, input bit f, input bit g,
                            input int s, input int sel);
    bit ld_ok, acc;
    int n;
    step_n++;
    e_fail = 0; e_ok = 0; e_err = 0;
    l = l && !c;
    f = f && !c && !l;
    g = g && !c && !l && !f;
    ld_ok = l && (s <= 9) && (sel < DIGITS);
    n = entry_num();
    if (m_mode == M_LOCK) begin
      if (MASTER_ON) begin
        entry_ops(c, ld_ok, f, s, sel);
        if (f && n == 99) begin
          m_mode = M_ENTRY; m_tries = 0; clear_entry();
          return;
        end
      end
      if (step_n >= lock_exit) begin
        m_mode = M_ENTRY; m_tries = 0; clear_entry();
      end
      return;
    end
    entry_ops(c, ld_ok, f, s, sel);
    if (m_mode == M_ENTRY) begin
      if (f) begin
        if (n == m_code || (MASTER_ON && n == 99)) begin
          m_mode = M_OPEN; m_tries = 0; idle_exit = step_n + OPEN_CYCLES;
        end else begin
          e_fail = 1; m_tries++;
          if (m_tries >= MAX_TRIES) begin
            m_mode = M_LOCK; lock_exit = step_n + LOCK_CYCLES;
          end
        end
      end
      return;
    end
    acc = c || ld_ok || f || (g && m_mode == M_OPEN);
    if (f) begin
      case (m_mode)
        M_OPEN: m_mode = M_ENTRY;
        M_NEW: begin m_cand = n; m_mode = M_VERIFY; end
        default: begin
          if (n == m_cand) begin m_code = n; e_ok = 1; end
          else e_err = 1;
          m_mode = M_OPEN;
        end
      endcase
    end else if (g && m_mode == M_OPEN) begin
      m_mode = M_NEW; clear_entry();
    end
    if (acc) idle_exit = step_n + OPEN_CYCLES;
    else if (step_n >= idle_exit) begin
      m_mode = M_ENTRY; clear_entry();
    end
  endtask

  function automatic logic [8:0] seg_of(input int d);
    case (d)
      0: return 9'h03F; 1: return 9'h006; 2: return 9'h05B; 3: return 9'h04F;
      4: return 9'h066; 5: return 9'h06D; 6: return 9'h07D; 7: return 9'h007;
      8: return 9'h07F; 9: return 9'h06F; default: return 9'h000;
    endcase
  endfunction

  task automatic check_model();
    logic [7:0]  ee;
    logic [17:0] es;
    for (int k = 0; k < DIGITS; k++) begin
      ee[4*k +: 4] = 4'(m_dig[k]);
      es[9*k +: 9] = seg_of(m_dig[k]);
    end
    chk("entry",      32'(entry),      32'(ee));
    chk("seg",        32'(seg),        32'(es));
    chk("unlocked",   32'(unlocked),   32'(m_mode == M_OPEN || m_mode == M_NEW || m_mode == M_VERIFY));
    chk("locked_out", 32'(locked_out), 32'(m_mode == M_LOCK));
    chk("fail",       32'(fail),       32'(e_fail));
    chk("change_ok",  32'(change_ok),  32'(e_ok));
    chk("change_err", 32'(change_err), 32'(e_err));
    chk("tries",      32'(tries),      32'(m_tries));
  endtask

  task automatic apply(input logic c, input logic l, input logic f, input logic g,
                       input logic [3:0] s, input logic sel);
    key_clear = c; key_load = l; key_confirm = f; key_change = g;
    sw = s; digit_sel = sel;
    @(posedge clk);
    model_step(c, l, f, g, int'(s), int'(sel));
    #1;
    check_model();
    key_clear = 0; key_load = 0; key_confirm = 0; key_change = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply(0, 0, 0, 0, 4'd0, 1'b0);
  endtask
  task automatic load2(input logic [3:0] d1, input logic [3:0] d0);
    apply(0, 1, 0, 0, d0, 1'b0);
    apply(0, 1, 0, 0, d1, 1'b1);
  endtask
  task automatic confirm(); apply(0, 0, 1, 0, 4'd0, 1'b0); endtask
  task automatic change();  apply(0, 0, 0, 1, 4'd0, 1'b0); endtask

  typedef struct {
    logic       c, l, f, g;
    logic [3:0] s;
    logic       sel;
    logic [7:0] e_entry;
    logic       e_unl;
    logic [3:0] e_tries;
    logic       e_fail;
    logic       e_lock;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic c, input logic l, input logic f, input logic g,
                     input logic [3:0] s, input logic sel, input logic [7:0] ee,
                     input logic eu, input logic [3:0] et, input logic ef, input logic el);
    vec_t v;
    v.c = c; v.l = l; v.f = f; v.g = g; v.s = s; v.sel = sel;
    v.e_entry = ee; v.e_unl = eu; v.e_tries = et; v.e_fail = ef; v.e_lock = el;
    vq.push_back(v);
  endtask

  initial begin
    int picks[4] = '{2, 4, 7, 9};
    logic c, l, f, g;
    logic [3:0] s;

    //  c  l  f  g  sw    sel   entry  unl tries fail lock
    add(0, 1, 0, 0, 4'd2, 1'b0, 8'h02, 0, 4'd0, 0, 0);
    add(0, 1, 0, 0, 4'd2, 1'b1, 8'h22, 0, 4'd0, 0, 0);
    add(0, 0, 1, 0, 4'd0, 1'b0, 8'h00, 1, 4'd0, 0, 0);
    add(0, 0, 1, 0, 4'd0, 1'b0, 8'h00, 0, 4'd0, 0, 0);
    add(0, 1, 0, 0, 4'd1, 1'b1, 8'h10, 0, 4'd0, 0, 0);
    add(0, 1, 0, 0, 4'd3, 1'b0, 8'h13, 0, 4'd0, 0, 0);
    add(0, 0, 1, 0, 4'd0, 1'b0, 8'h00, 0, 4'd1, 1, 0);
    add(0, 1, 0, 0, 4'd1, 1'b1, 8'h10, 0, 4'd1, 0, 0);
    add(0, 1, 0, 0, 4'd3, 1'b0, 8'h13, 0, 4'd1, 0, 0);
    add(0, 0, 1, 0, 4'd0, 1'b0, 8'h00, 0, 4'd2, 1, 0);
    add(0, 1, 0, 0, 4'd1, 1'b1, 8'h10, 0, 4'd2, 0, 0);
    add(0, 1, 0, 0, 4'd3, 1'b0, 8'h13, 0, 4'd2, 0, 0);
    add(0, 0, 1, 0, 4'd0, 1'b0, 8'h00, 0, 4'd3, 1, 1);
    add(0, 0, 1, 0, 4'd0, 1'b0, 8'h00, 0, 4'd3, 0, 1);
    add(0, 0, 0, 1, 4'd0, 1'b0, 8'h00, 0, 4'd3, 0, 1);
    add(1, 0, 0, 0, 4'd0, 1'b0, 8'h00, 0, 4'd3, 0, 1);

    rst_n = 0; sw = 0; digit_sel = 0;
    key_load = 0; key_confirm = 0; key_change = 0; key_clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    chk("rst_seg", 32'(seg), 32'({9'h03F, 9'h03F}));
    @(negedge clk);
    rst_n = 1;

    foreach (vq[i]) begin
      apply(vq[i].c, vq[i].l, vq[i].f, vq[i].g, vq[i].s, vq[i].sel);
      chk($sformatf("tbl%0d_entry", i), 32'(entry),      32'(vq[i].e_entry));
      chk($sformatf("tbl%0d_unl", i),   32'(unlocked),   32'(vq[i].e_unl));
      chk($sformatf("tbl%0d_tries", i), 32'(tries),      32'(vq[i].e_tries));
      chk($sformatf("tbl%0d_fail", i),  32'(fail),       32'(vq[i].e_fail));
      chk($sformatf("tbl%0d_lock", i),  32'(locked_out), 32'(vq[i].e_lock));
    end

    // Lockout began at the 13th vector; 3 vectors + 16 idle cycles keeps it held
    idle(16);
    chk("lock_hold", 32'(locked_out), 32'd1);
    idle(1);
    chk("lock_exit", 32'(locked_out), 32'd0);
    chk("lock_tries", 32'(tries), 32'd0);

    // Verify mismatch keeps the old code, then a good change
    load2(2, 2); confirm();
    chk("open22", 32'(unlocked), 32'd1);
    change(); load2(4, 7); confirm(); load2(4, 8); confirm();
    chk("chg_err", 32'(change_err), 32'd1);
    chk("err_open", 32'(unlocked), 32'd1);
    confirm();
    load2(2, 2); confirm();
    chk("code_kept", 32'(unlocked), 32'd1);
    change(); load2(4, 7); confirm(); load2(4, 7); confirm();
    chk("chg_ok", 32'(change_ok), 32'd1);
    confirm();
    load2(2, 2); confirm();
    chk("old_fails", 32'(fail), 32'd1);
    load2(4, 7); confirm();
    chk("new_opens", 32'(unlocked), 32'd1);
    chk("new_tries0", 32'(tries), 32'd0);

    // Key priority, invalid digit, then inactivity relock
    apply(0, 1, 0, 0, 4'd5, 1'b0);
    chk("ld5", 32'(entry), 32'h05);
    apply(1, 1, 0, 0, 4'd7, 1'b1);
    chk("clr_wins", 32'(entry), 32'h00);
    apply(0, 1, 0, 0, 4'd3, 1'b1);
    apply(0, 1, 0, 0, 4'hA, 1'b0);
    chk("sw_a_ignored", 32'(entry), 32'h30);
    apply(1, 0, 0, 0, 4'd0, 1'b0);
    idle(OPEN_CYCLES - 1);
    chk("idle_hold", 32'(unlocked), 32'd1);
    idle(1);
    chk("idle_relock", 32'(unlocked), 32'd0);

    // Async reset in the middle of a lockout
    repeat (3) begin load2(1, 3); confirm(); end
    chk("lock2", 32'(locked_out), 32'd1);
    idle(5);
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("rst_lock", 32'(locked_out), 32'd0);
    chk("rst_tries", 32'(tries), 32'd0);
    chk("rst_entry", 32'(entry), 32'd0);
    @(negedge clk);
    rst_n = 1;
    load2(2, 2); confirm();
    chk("rst_code", 32'(unlocked), 32'd1);
    confirm();

`ifdef MASTER_CODE_EN
    repeat (3) begin load2(1, 3); confirm(); end
    load2(9, 9); confirm();
    chk("master_exit", 32'(locked_out), 32'd0);
    chk("master_tries", 32'(tries), 32'd0);
    load2(9, 9); confirm();
    chk("master_open", 32'(unlocked), 32'd1);
    confirm();
`endif

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) idle(OPEN_CYCLES + 5);
      if ($urandom_range(0, 9) == 0) begin
        c = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
        f = 1'($urandom_range(0, 1)); g = 1'($urandom_range(0, 1));
      end else begin
        int r = int'($urandom_range(0, 15));
        c = (r == 0); l = (r >= 1 && r <= 6); f = (r == 7 || r == 8); g = (r == 9);
      end
      if ($urandom_range(0, 3) != 0) s = 4'(picks[$urandom_range(0, 3)]);
      else s = 4'($urandom_range(0, 15));
      apply(c, l, f, g, s, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/code_lock.md
Name: code_lock

Overview:
- Parametrised digital combination lock: DIGITS-digit BCD code entered from a 4-bit switch bank, one digit per load pulse.
- Bounded failed-attempt counter with timed lockout; verified two-step code change while open; inactivity auto-relock.
- Sits behind the board key debouncer; drives status LEDs and per-digit 7-segment displays.

Parameters:
- DIGITS, 2: number of code digits, range 1..8.
- MAX_TRIES, 3: consecutive failures that trigger lockout, range 1..15.
- LOCK_CYCLES, 50_000_000: lockout duration in clk cycles.
- OPEN_CYCLES, 500_000_000: idle cycles in OPEN before auto-relock.
- INIT_CODE, {DIGITS{4'd2}}: reset code, 4*DIGITS bits; digit 0 in LSBs.
- MASTER_CODE, {DIGITS{4'd9}}: used only with MASTER_CODE_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  4  BCD digit from switches
- digit_sel  in  $clog2(DIGITS) (min 1)  digit position written by key_load
- key_load  in  1  debounced 1-cycle pulse: write sw into entry[digit_sel]
- key_confirm  in  1  debounced pulse: submit entry
- key_change  in  1  debounced pulse: start code change (OPEN only)
- key_clear  in  1  debounced pulse: zero entry
- entry  out  4*DIGITS  current entry buffer
- unlocked  out  1  high in OPEN, CHANGE_NEW, CHANGE_VERIFY
- locked_out  out  1  high in LOCKOUT
- fail  out  1  1-cycle pulse on wrong code
- change_ok  out  1  1-cycle pulse when new code committed
- change_err  out  1  1-cycle pulse when verify mismatches
- tries  out  4  consecutive failure count
- seg  out  9*DIGITS  per-digit {2'b00, gfedcba} active-high

Behaviour:
- Reset (async assert, sync release): state=ENTRY, code=INIT_CODE, entry=0, tries=0, all pulses 0, timers 0, seg shows all zeros (0x3F per digit).
- Key priority in one cycle: key_clear > key_load > key_confirm > key_change; lower keys ignored that cycle.
- key_load: sw>9 ignored (entry unchanged); digit_sel>=DIGITS ignored. Entry updates the cycle after the pulse.
- Every accepted key_confirm clears entry next cycle; outputs registered, 1-cycle latency.
- States: ENTRY, OPEN, CHANGE_NEW, CHANGE_VERIFY, LOCKOUT.
- ENTRY, confirm: entry==code -> OPEN, tries=0. Else fail pulse, tries+1; if new tries==MAX_TRIES -> LOCKOUT, timer loaded.
- LOCKOUT: all keys ignored; after exactly LOCK_CYCLES cycles -> ENTRY, tries=0, entry=0.
- OPEN: key_confirm -> ENTRY (manual relock); key_change -> CHANGE_NEW, entry=0.
- CHANGE_NEW, confirm: candidate=entry -> CHANGE_VERIFY. CHANGE_VERIFY, confirm: entry==candidate -> code=candidate, change_ok, OPEN; else change_err, code kept, OPEN.
- Idle timer: counts in OPEN/CHANGE_*, reset by any accepted key; reaching OPEN_CYCLES -> ENTRY, change discarded.
- Counters saturate; no wrap. tries never exceeds MAX_TRIES.
- seg digit k decodes entry[4k+3:4k]; values >9 impossible by construction.

Optional Feature:
- MASTER_CODE_EN defined: in LOCKOUT, key_confirm is accepted; entry==MASTER_CODE -> ENTRY, tries=0, timer cleared; mismatch ignored (no fail, no timer change). In ENTRY, MASTER_CODE also opens.
- Undefined: no master-code logic; LOCKOUT ignores all keys.

Decomposition:
- Package code_lock_pkg: state encoding constants, 7-segment digit patterns 0..9, width helper for digit_sel.
- Sub-module seg7_bcd_decode (one 4-bit digit -> 9-bit pattern), instantiated DIGITS times via generate.

Test Plan:
- Reset, load 2@0, 2@1, confirm -> unlocked=1 cycle after confirm, tries=0, entry=0.
- Wrong 13 three times -> fail pulse each, tries 1,2,3, locked_out=1; keys ignored; exits to ENTRY after LOCK_CYCLES (bench override 20).
- Open, change, enter 47, confirm, 47, confirm -> change_ok; relock; 22 fails, 47 opens.
- Change verify mismatch (47 then 48) -> change_err, code still 22, stays OPEN.
- Same-cycle key_clear+key_load -> entry=0; sw=4'hA load -> entry unchanged; idle OPEN_CYCLES (override 30) -> ENTRY.
- rst_n low mid-LOCKOUT -> immediate ENTRY, tries=0; with MASTER_CODE_EN, 99 in lockout -> ENTRY.
